// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, fetches over a req/ack handshake,
// then picks sequential, relative-branch or page-local-jump successor once resolved.
module pc_sequencer #(
    parameter int unsigned     PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic            instr_valid,
    output logic [7:0]      instr,
    input  logic            resolve_valid,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            halt,
    input  logic [7:0]      offset,
    input  logic [4:0]      target,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [7:0]      retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RESOLVE,
        S_HALT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_wait_cnt;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic [7:0]      r_instr;
    logic            r_busy;
    logic            r_halted;
    logic            r_err;
    logic [7:0]      r_retire_cnt;

    state_t          w_state_next;
    logic [PC_W-1:0] w_pc_next;
    logic [7:0]      w_wait_next;
    logic            w_req_next;
    logic            w_valid_next;
    logic [7:0]      w_instr_next;
    logic            w_err_next;
    logic [7:0]      w_retire_next;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_branch_pc;
    logic [PC_W-1:0] w_jump_pc;

    assign w_seq_pc    = r_pc + PC_W'(1);
    // Size-casting the signed offset sign-extends it before the modular add.
    assign w_branch_pc = w_seq_pc + PC_W'($signed(offset));
    assign w_jump_pc   = {r_pc[PC_W-1:5], target};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_wait_next   = r_wait_cnt;
        w_req_next    = 1'b0;
        w_valid_next  = 1'b0;
        w_instr_next  = r_instr;
        w_err_next    = r_err;
        w_retire_next = r_retire_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_req_next   = 1'b1;
                    w_wait_next  = 8'd0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_next = S_RESOLVE;
                    w_instr_next = imem_data;
                    w_valid_next = 1'b1;
                    w_wait_next  = 8'd0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = S_HALT;
                    w_err_next   = 1'b1;
                    w_wait_next  = 8'd0;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                    w_req_next  = 1'b1;
                end
            end
            S_RESOLVE: begin
                if (resolve_valid && !stall) begin
                    if (halt) begin
                        w_state_next = S_HALT;
                    end else begin
                        if (jump)              w_pc_next = w_jump_pc;
                        else if (branch_taken) w_pc_next = w_branch_pc;
                        else                   w_pc_next = w_seq_pc;
                        w_retire_next = r_retire_cnt + 8'd1;
                        w_state_next  = S_FETCH;
                        w_req_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_wait_cnt    <= 8'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 8'd0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
            r_retire_cnt  <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_wait_cnt    <= w_wait_next;
            r_imem_req    <= w_req_next;
            r_instr_valid <= w_valid_next;
            r_instr       <= w_instr_next;
            r_busy        <= (w_state_next == S_FETCH) || (w_state_next == S_RESOLVE);
            r_halted      <= (w_state_next == S_HALT);
            r_err         <= w_err_next;
            r_retire_cnt  <= w_retire_next;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign err         = r_err;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, multi-cycle corner sequences, and a
// randomized run against an arithmetic next-PC model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, imem_req, imem_ack, instr_valid;
    logic [7:0] imem_addr, imem_data, instr, pc, offset, retire_cnt;
    logic       resolve_valid, branch_taken, jump, halt, stall;
    logic [4:0] target;
    logic       busy, halted, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr),
        .resolve_valid(resolve_valid), .branch_taken(branch_taken),
        .jump(jump), .halt(halt), .offset(offset), .target(target),
        .stall(stall), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic       br;
        logic       jmp;
        logic [7:0] off;
        logic [4:0] tgt;
        logic [7:0] data;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_next(int p, bit br, bit jmp, int off, int tgt);
        int o;
        if (jmp) return 8'((p / 32) * 32 + tgt);
        o = (off >= 128) ? off - 256 : off;
        if (br) return 8'((p + 1 + o + 256) % 256);
        return 8'((p + 1) % 256);
    endfunction

    // Expects FETCH with imem_req up; holds ack low for lat cycles, then acks.
    task automatic fetch(input int lat, input logic [7:0] data, input logic [7:0] exp_addr);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, exp_addr);
        repeat (lat) step();
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        check("instr_valid_pulse", instr_valid, 1);
        check("instr_latched", instr, data);
        check("busy_resolve", busy, 1);
        check("req_drop", imem_req, 0);
    endtask

    task automatic resolve(input logic br, input logic jmp, input logic hlt,
                           input logic [7:0] off, input logic [4:0] tgt);
        resolve_valid = 1'b1;
        branch_taken  = br;
        jump          = jmp;
        halt          = hlt;
        offset        = off;
        target        = tgt;
        step();
        resolve_valid = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        halt          = 1'b0;
        offset        = 8'($urandom);
        target        = 5'($urandom);
        check("instr_valid_one_cycle", instr_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] m_pc;
        logic [7:0] m_ret;
        logic       r_br, r_jmp;
        logic [7:0] r_off;
        logic [4:0] r_tgt;

        vecs[0] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'hA5, 8'h01};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 5'h10, 8'h11, 8'h10};
        vecs[2] = '{1'b1, 1'b0, 8'hFC, 5'h00, 8'h22, 8'h0D};
        vecs[3] = '{1'b1, 1'b0, 8'hF0, 5'h00, 8'h33, 8'hFE};
        vecs[4] = '{1'b1, 1'b0, 8'h05, 5'h00, 8'h44, 8'h04};
        vecs[5] = '{1'b1, 1'b0, 8'h65, 5'h00, 8'h55, 8'h6A};
        vecs[6] = '{1'b1, 1'b1, 8'h7F, 5'h13, 8'h66, 8'h73};
        vecs[7] = '{1'b1, 1'b0, 8'h8B, 5'h00, 8'h77, 8'hFF};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h88, 8'h00};
        vecs[9] = '{1'b0, 1'b0, 8'h7F, 5'h1F, 8'h99, 8'h01};

        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
        resolve_valid = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
        offset = 8'h00; target = 5'h00; stall = 1'b0;
        step();
        step();
        check("rst_pc", pc, 8'h00);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_retire", retire_cnt, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);

        rst_n = 1'b1;
        step();
        check("idle_hold_busy", busy, 0);
        check("idle_hold_req", imem_req, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);

        // Table: fetch each entry, resolve it, check the successor PC.
        exp_pc = 8'h00;
        for (int i = 0; i < 10; i++) begin
            fetch(1, vecs[i].data, exp_pc);
            resolve(vecs[i].br, vecs[i].jmp, 1'b0, vecs[i].off, vecs[i].tgt);
            exp_pc = vecs[i].exp_pc;
            check("vec_pc", pc, exp_pc);
            check("vec_addr", imem_addr, exp_pc);
            check("vec_req", imem_req, 1);
            check("vec_retire", retire_cnt, 8'(i + 1));
            check("vec_instr_held", instr, vecs[i].data);
        end

        // Stall holds a pending resolve for three cycles.
        fetch(1, 8'hC3, 8'h01);
        stall = 1'b1;
        resolve_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 8'h01);
            check("stall_retire", retire_cnt, 8'd10);
            check("stall_req", imem_req, 0);
            check("stall_busy", busy, 1);
        end
        stall = 1'b0;
        step();
        resolve_valid = 1'b0;
        check("unstall_pc", pc, 8'h02);
        check("unstall_retire", retire_cnt, 8'd11);
        check("unstall_req", imem_req, 1);

        // Ack on the last allowed FETCH cycle beats the timeout.
        fetch(14, 8'h3C, 8'h02);
        check("late_ack_no_err", err, 0);
        resolve(1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
        check("late_ack_pc", pc, 8'h03);

        // Reset mid-fetch at pc=22, with a stale ack afterwards.
        fetch(0, 8'h47, 8'h03);
        resolve(1'b1, 1'b0, 1'b0, 8'h1E, 5'h00);
        check("mid_pc", imem_addr, 8'h22);
        check("mid_retire", retire_cnt, 8'd13);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_data = 8'hEE;
        check("midrst_pc", pc, 8'h00);
        check("midrst_req", imem_req, 0);
        check("midrst_valid", instr_valid, 0);
        check("midrst_retire", retire_cnt, 8'd0);
        step();
        imem_ack = 1'b0;
        check("stale_ack_valid", instr_valid, 0);
        check("stale_ack_instr", instr, 8'h00);
        check("stale_ack_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        fetch(2, 8'h5A, 8'h00);
        resolve(1'b1, 1'b1, 1'b1, 8'h10, 5'h1F);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_retire", retire_cnt, 8'd0);
        check("halt_pc", pc, 8'h00);
        check("halt_req", imem_req, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("halt_ignores_start", halted, 1);
        check("halt_ignores_start_req", imem_req, 0);

        // Ack timeout: fifteen unacknowledged FETCH cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_req", imem_req, 1);
        repeat (14) step();
        check("to_not_yet_err", err, 0);
        check("to_not_yet_req", imem_req, 1);
        step();
        check("to_err", err, 1);
        check("to_halted", halted, 1);
        check("to_req_low", imem_req, 0);
        check("to_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("to_start_ignored", halted, 1);
        check("to_err_sticky", err, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("to_rst_err", err, 0);
        check("to_rst_halted", halted, 0);
        check("to_rst_busy", busy, 0);

        // Randomized run against the arithmetic model.
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = 8'h00;
        m_ret = 8'h00;
        for (int t = 0; t < 150; t++) begin
            fetch($urandom_range(0, 6), 8'($urandom), m_pc);
            repeat ($urandom_range(0, 2)) begin
                branch_taken = 1'($urandom); jump = 1'($urandom); halt = 1'($urandom);
                offset = 8'($urandom); target = 5'($urandom);
                step();
                check("rnd_idle_pc", pc, m_pc);
            end
            repeat ($urandom_range(0, 2)) begin
                stall = 1'b1;
                resolve_valid = 1'($urandom);
                branch_taken = 1'($urandom); jump = 1'($urandom); halt = 1'($urandom);
                step();
                check("rnd_stall_pc", pc, m_pc);
                check("rnd_stall_retire", retire_cnt, m_ret);
            end
            stall = 1'b0;
            resolve_valid = 1'b0;
            r_br  = 1'($urandom);
            r_jmp = ($urandom_range(0, 3) == 0);
            r_off = 8'($urandom);
            r_tgt = 5'($urandom);
            resolve(r_br, r_jmp, 1'b0, r_off, r_tgt);
            m_pc  = model_next(int'(m_pc), r_br, r_jmp, int'(r_off), int'(r_tgt));
            m_ret = m_ret + 8'd1;
            check("rnd_pc", pc, m_pc);
            check("rnd_addr", imem_addr, m_pc);
            check("rnd_retire", retire_cnt, m_ret);
        end
        fetch(3, 8'h76, m_pc);
        resolve(1'b0, 1'b0, 1'b1, 8'h00, 5'h00);
        check("rnd_halt", halted, 1);
        check("rnd_halt_retire", retire_cnt, m_ret);
        check("rnd_halt_pc", pc, m_pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/next-PC controller for the 8-bit processor.
- Owns the program counter register and drives instruction-memory fetch with a req/ack handshake.
- Waits for the decode/execute stage to resolve each instruction, then selects the next PC: sequential, relative branch, or page-local jump.
- Sits between instruction memory and the decode stage; it replaces open-loop PC update with a sequenced, stall-aware FSM.

Parameters:
- PC_W, 8, PC and instruction-memory address width.
- RESET_PC, 8'h00, PC value loaded on reset.
- ACK_TIMEOUT, 15, maximum FETCH cycles without imem_ack before the error halt (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_data is valid in the same cycle.
- imem_data  in  8  fetched instruction.
- instr_valid  out  1  one-cycle pulse; instr is newly valid.
- instr  out  8  last fetched instruction, held until the next fetch completes.
- resolve_valid  in  1  decode/execute has resolved the current instruction.
- branch_taken  in  1  conditional branch taken (qualified by resolve_valid).
- jump  in  1  unconditional jump (qualified by resolve_valid).
- halt  in  1  halt instruction (qualified by resolve_valid).
- offset  in  8  signed two's-complement branch offset.
- target  in  5  jump target, low 5 PC bits.
- stall  in  1  freeze the sequencer in RESOLVE.
- pc  out  PC_W  current PC.
- busy  out  1  high in FETCH or RESOLVE.
- halted  out  1  high in HALT.
- err  out  1  sticky; set on ack timeout.
- retire_cnt  out  8  count of resolved non-halt instructions; wraps modulo 256.

Behaviour:
- Reset (rst_n=0 at an edge, in any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC.
  - imem_req, instr_valid, halted, err all 0; instr=0, retire_cnt=0, wait counter=0.
  - An outstanding fetch is abandoned. An imem_ack arriving after reset is ignored.
- States: IDLE, FETCH, RESOLVE, HALT. All outputs are registered.
- IDLE:
  - start=1 -> FETCH.
  - Otherwise stay; pc holds.
- FETCH:
  - imem_req=1, imem_addr=pc, wait counter increments each cycle.
  - imem_ack=1 -> latch instr<=imem_data, pulse instr_valid for the next cycle only, clear counter, go to RESOLVE.
  - Wait counter reaches ACK_TIMEOUT without ack -> err<=1, imem_req<=0, go to HALT.
  - Ack in the same cycle the counter would hit the limit: the ack wins.
  - Minimum latency: req asserted in cycle N, ack in N -> instr_valid in N+1.
- RESOLVE:
  - imem_req=0. While stall=1, resolve inputs are ignored and all state holds.
  - On resolve_valid=1 with stall=0, priority is halt > jump > branch_taken > sequential:
    - halt: go to HALT; pc unchanged; retire_cnt unchanged.
    - jump: pc <= {pc[7:5], target}.
    - branch_taken: pc <= pc + 1 + sign-extended offset, modulo 256.
    - otherwise: pc <= pc + 1, modulo 256 (8'hFF wraps to 8'h00).
  - For the jump, branch and sequential cases, retire_cnt increments and FETCH is entered next cycle.
  - resolve_valid arriving in the same cycle as the instr_valid pulse is accepted.
- HALT:
  - halted=1, busy=0. Only reset exits HALT; start is ignored.
- busy equals 1 exactly when state is FETCH or RESOLVE.

Test Plan:
1. Reset then start, with imem_ack one cycle after req, data 8'hA5, sequential resolve -> instr=8'hA5, instr_valid pulses once, pc 00->01, retire_cnt=1, next imem_addr=01.
2. pc=8'h10, branch_taken with offset=8'hFC (-4) -> pc=8'h0D; pc=8'hFE, offset=8'h05 -> pc=8'h04 (wrap).
3. pc=8'h6A with jump=1, branch_taken=1, target=5'h13 -> pc=8'h73 (jump wins); pc=8'hFF sequential -> 8'h00.
4. stall=1 held for 3 cycles with resolve_valid=1 -> pc unchanged; release stall -> pc updates once, retire_cnt +1.
5. imem_ack never asserted, ACK_TIMEOUT=15 -> after 15 FETCH cycles err=1, halted=1, imem_req=0; start ignored; rst_n=0 clears err and returns to IDLE.
6. rst_n pulled low mid-FETCH at pc=8'h22 with a late ack -> pc=RESET_PC, imem_req=0, no instr_valid; halt resolve later -> halted=1, retire_cnt unchanged.
